// File: rtl/head_ball_contact.sv
// Per-player head/ball contact and kick controller: emits a one-frame saturated force impulse.
// Optional kick path enabled by defining HEAD_BALL_KICK_EN; default build generates bumps only.
module head_ball_contact #(
    parameter int HEAD_R          = 20,
    parameter int BUMP            = 4,
    parameter int KICK_VX         = 12,
    parameter int KICK_VY         = -10,
    parameter int KICK_REACH      = 10,
    parameter int MAX_FORCE       = 15,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              goal_reset,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic signed [9:0] PlayerVelX,
    input  logic              facing,
    input  logic              kick_btn,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    input  logic [9:0]        BallS,
    input  logic signed [9:0] BallVelX,
    input  logic signed [9:0] BallVelY,
    output logic              apply_force,
    output logic signed [9:0] force_x,
    output logic signed [9:0] force_y,
    output logic              contact
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

    localparam logic signed [11:0] C_BUMP    = 12'(BUMP);
    localparam logic signed [11:0] C_KICK_VX = 12'(KICK_VX);
    localparam logic signed [11:0] C_KICK_VY = 12'(KICK_VY);
    localparam logic signed [11:0] C_MAX     = 12'(MAX_FORCE);
    localparam logic signed [11:0] C_MIN     = -C_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_COOLDOWN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic [11:0]        w_abs_dx;
    logic [11:0]        w_abs_dy;
    logic [11:0]        w_dist;
    logic [11:0]        w_touch_thr;
    logic [11:0]        w_reach_thr;
    logic               w_touch;
    logic               w_reach;

    logic signed [11:0] w_pvx_ext;
    logic signed [11:0] w_bvy_pos;
    logic signed [11:0] w_bump_x;
    logic signed [11:0] w_bump_y;
    logic signed [11:0] w_kick_x;
    logic signed [11:0] w_kick_y;
    logic signed [11:0] w_raw_x;
    logic signed [11:0] w_raw_y;
    logic               w_kick_edge;
    logic               w_take_kick;
    logic               w_fire;
    logic               w_unused;

    // Manhattan distance; off-screen (wrapped) ball coordinates simply look far away.
    assign w_dx        = $signed({2'b00, BallX}) - $signed({2'b00, PlayerX});
    assign w_dy        = $signed({2'b00, BallY}) - $signed({2'b00, PlayerY});
    assign w_abs_dx    = w_dx[11] ? -w_dx : w_dx;
    assign w_abs_dy    = w_dy[11] ? -w_dy : w_dy;
    assign w_dist      = w_abs_dx + w_abs_dy;
    assign w_touch_thr = 12'(HEAD_R) + {2'b00, BallS};
    assign w_reach_thr = w_touch_thr + 12'(KICK_REACH);
    assign w_touch     = (w_dist <= w_touch_thr);
    assign w_reach     = (w_dist <= w_reach_thr);

    assign w_pvx_ext = {{2{PlayerVelX[9]}}, PlayerVelX};
    assign w_bvy_pos = BallVelY[9] ? 12'sd0 : $signed({2'b00, BallVelY});
    assign w_bump_x  = (w_dx[11] ? -C_BUMP : C_BUMP) + w_pvx_ext;
    assign w_bump_y  = w_dy[11] ? (-C_BUMP - w_bvy_pos) : C_BUMP;
    assign w_kick_x  = facing ? C_KICK_VX : -C_KICK_VX;
    assign w_kick_y  = C_KICK_VY;

`ifdef HEAD_BALL_KICK_EN
    logic r_kick_prev;

    // Tracks the button in every state so a held button never re-triggers after cooldown.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_kick_prev <= 1'b0;
        end else begin
            r_kick_prev <= kick_btn;
        end
    end

    assign w_kick_edge = kick_btn & ~r_kick_prev;
    assign w_unused    = ^BallVelX;
`else
    assign w_kick_edge = 1'b0;
    assign w_unused    = ^{BallVelX, kick_btn};
`endif

    assign w_take_kick = w_kick_edge & w_reach;
    assign w_fire      = w_take_kick | w_touch;
    assign w_raw_x     = w_take_kick ? w_kick_x : w_bump_x;
    assign w_raw_y     = w_take_kick ? w_kick_y : w_bump_y;

    function automatic logic signed [9:0] sat_force(input logic signed [11:0] v);
        logic signed [11:0] c;
        if (v > C_MAX) begin
            c = C_MAX;
        end else if (v < C_MIN) begin
            c = C_MIN;
        end else begin
            c = v;
        end
        return c[9:0];
    endfunction

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            apply_force <= 1'b0;
            force_x     <= '0;
            force_y     <= '0;
            contact     <= 1'b0;
        end else if (goal_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            apply_force <= 1'b0;
            force_x     <= '0;
            force_y     <= '0;
            contact     <= 1'b0;
        end else begin
            contact <= w_touch;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_state     <= S_PUSH;
                        apply_force <= 1'b1;
                        force_x     <= sat_force(w_raw_x);
                        force_y     <= sat_force(w_raw_y);
                    end
                end
                S_PUSH: begin
                    r_state     <= S_COOLDOWN;
                    r_cnt       <= CNT_LOAD;
                    apply_force <= 1'b0;
                    force_x     <= '0;
                    force_y     <= '0;
                end
                S_COOLDOWN: begin
                    // Contacts seen here are dropped, not queued.
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    apply_force <= 1'b0;
                    force_x     <= '0;
                    force_y     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_head_ball_contact.sv
// Directed self-checking bench for head_ball_contact (bump, saturation, cooldown, resets, kick).
module tb_head_ball_contact;

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b1;
    logic              goal_reset = 1'b0;
    logic [9:0]        PlayerX = 10'd300;
    logic [9:0]        PlayerY = 10'd300;
    logic signed [9:0] PlayerVelX = '0;
    logic              facing = 1'b0;
    logic              kick_btn = 1'b0;
    logic [9:0]        BallX = 10'd320;
    logic [9:0]        BallY = 10'd290;
    logic [9:0]        BallS = 10'd15;
    logic signed [9:0] BallVelX = '0;
    logic signed [9:0] BallVelY = 10'sd3;
    logic              apply_force;
    logic signed [9:0] force_x;
    logic signed [9:0] force_y;
    logic              contact;

    int checks = 0;
    int failures = 0;

    head_ball_contact dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .goal_reset (goal_reset),
        .PlayerX    (PlayerX),
        .PlayerY    (PlayerY),
        .PlayerVelX (PlayerVelX),
        .facing     (facing),
        .kick_btn   (kick_btn),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .BallVelX   (BallVelX),
        .BallVelY   (BallVelY),
        .apply_force(apply_force),
        .force_x    (force_x),
        .force_y    (force_y),
        .contact    (contact)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_geom(input int px, input int py, input int bx, input int by,
                            input int bs, input int bvy, input int pvx);
        PlayerX    = 10'(px);
        PlayerY    = 10'(py);
        BallX      = 10'(bx);
        BallY      = 10'(by);
        BallS      = 10'(bs);
        BallVelY   = 10'(bvy);
        PlayerVelX = 10'(pvx);
    endtask

    task automatic recover();
        set_geom(100, 100, 600, 400, 15, 0, 0);
        kick_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        repeat (3) tick();
        $display("reset: af=%0b fx=%0d fy=%0d contact=%0b", apply_force, force_x, force_y, contact);
        checks++; if (apply_force !== 1'b0) begin failures++; $display("FAIL reset_af: got %0b want 0", apply_force); end
        checks++; if (force_x !== 10'sd0) begin failures++; $display("FAIL reset_fx: got %0d want 0", force_x); end
        checks++; if (force_y !== 10'sd0) begin failures++; $display("FAIL reset_fy: got %0d want 0", force_y); end
        checks++; if (contact !== 1'b0) begin failures++; $display("FAIL reset_contact: got %0b want 0", contact); end
        set_geom(100, 100, 600, 400, 15, 0, 0);
        Reset = 1'b0;
        repeat (2) tick();
        checks++; if (apply_force !== 1'b0) begin failures++; $display("FAIL post_reset_af: got %0b want 0", apply_force); end
    endtask

    task automatic test_bump();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        tick();
        $display("bump: af=%0b fx=%0d fy=%0d contact=%0b", apply_force, force_x, force_y, contact);
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL bump_af: got %0b want 1", apply_force); end
        checks++; if (force_x !== 10'sd4) begin failures++; $display("FAIL bump_fx: got %0d want 4", force_x); end
        checks++; if (force_y !== -10'sd7) begin failures++; $display("FAIL bump_fy: got %0d want -7", force_y); end
        checks++; if (contact !== 1'b1) begin failures++; $display("FAIL bump_contact: got %0b want 1", contact); end
        set_geom(100, 100, 600, 400, 15, 0, 0);
        tick();
        $display("bump+1: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (apply_force !== 1'b0) begin failures++; $display("FAIL bump_one_frame: got %0b want 0", apply_force); end
        checks++; if (force_x !== 10'sd0 || force_y !== 10'sd0) begin
            failures++; $display("FAIL bump_force_cleared: got %0d,%0d want 0,0", force_x, force_y);
        end
        recover();
    endtask

    task automatic test_no_contact();
        int pulses;
        int touches;
        pulses = 0;
        touches = 0;
        set_geom(300, 300, 336, 300, 15, 0, 0);
        for (int f = 0; f < 20; f++) begin
            tick();
            pulses += int'(apply_force);
            touches += int'(contact);
        end
        $display("no_contact: pulses=%0d contacts=%0d", pulses, touches);
        checks++; if (pulses != 0) begin failures++; $display("FAIL no_contact_pulses: got %0d want 0", pulses); end
        checks++; if (touches != 0) begin failures++; $display("FAIL no_contact_contact: got %0d want 0", touches); end
        set_geom(20, 300, 974, 300, 15, 0, 0);
        repeat (3) tick();
        $display("wrapped ball: af=%0b contact=%0b", apply_force, contact);
        checks++; if (apply_force !== 1'b0 || contact !== 1'b0) begin
            failures++; $display("FAIL wrapped_ball: got af=%0b contact=%0b want 0,0", apply_force, contact);
        end
        set_geom(300, 300, 335, 300, 15, 0, 0);
        tick();
        $display("boundary dist35: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL boundary_touch: got %0b want 1", apply_force); end
        checks++; if (force_y !== 10'sd4) begin failures++; $display("FAIL boundary_fy: got %0d want 4", force_y); end
        recover();
    endtask

    task automatic test_saturation();
        set_geom(300, 300, 320, 290, 15, 3, 14);
        tick();
        $display("sat+: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (force_x !== 10'sd15) begin failures++; $display("FAIL sat_pos_fx: got %0d want 15", force_x); end
        checks++; if (force_y !== -10'sd7) begin failures++; $display("FAIL sat_pos_fy: got %0d want -7", force_y); end
        recover();
        set_geom(300, 300, 280, 310, 15, 0, -14);
        tick();
        $display("sat-: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (force_x !== -10'sd15) begin failures++; $display("FAIL sat_neg_fx: got %0d want -15", force_x); end
        checks++; if (force_y !== 10'sd4) begin failures++; $display("FAIL sat_neg_fy: got %0d want 4", force_y); end
        recover();
        set_geom(300, 300, 320, 290, 15, 20, 0);
        tick();
        $display("sat y: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (force_y !== -10'sd15) begin failures++; $display("FAIL sat_y: got %0d want -15", force_y); end
        recover();
        set_geom(300, 300, 320, 290, 15, -5, 0);
        tick();
        $display("neg ballvely: fx=%0d fy=%0d", force_x, force_y);
        checks++; if (force_y !== -10'sd4) begin failures++; $display("FAIL neg_bvy_fy: got %0d want -4", force_y); end
        recover();
    endtask

    task automatic test_cooldown();
        logic [25:1] obs;
        logic [25:1] exp_v;
        obs = '0;
        exp_v = '0;
        exp_v[1] = 1'b1;
        exp_v[11] = 1'b1;
        exp_v[21] = 1'b1;
        set_geom(300, 300, 320, 290, 15, 3, 0);
        for (int f = 1; f <= 25; f++) begin
            tick();
            obs[f] = apply_force;
        end
        $display("cooldown pulses frames 25..1: %b", obs);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL cooldown_period: got %b want %b", obs, exp_v); end
        recover();
    endtask

    task automatic test_goal_reset();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        tick();
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL gr_first_pulse: got %0b want 1", apply_force); end
        repeat (3) tick();
        goal_reset = 1'b1;
        tick();
        goal_reset = 1'b0;
        $display("goal_reset edge: af=%0b contact=%0b", apply_force, contact);
        checks++; if (apply_force !== 1'b0 || contact !== 1'b0) begin
            failures++; $display("FAIL gr_outputs: got af=%0b contact=%0b want 0,0", apply_force, contact);
        end
        tick();
        $display("after goal_reset: af=%0b fx=%0d fy=%0d", apply_force, force_x, force_y);
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL gr_repulse: got %0b want 1", apply_force); end
        checks++; if (force_x !== 10'sd4) begin failures++; $display("FAIL gr_repulse_fx: got %0d want 4", force_x); end
        recover();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        goal_reset = 1'b1;
        tick();
        goal_reset = 1'b0;
        $display("goal_reset vs touch: af=%0b", apply_force);
        checks++; if (apply_force !== 1'b0) begin failures++; $display("FAIL gr_priority: got %0b want 0", apply_force); end
        tick();
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL gr_priority_next: got %0b want 1", apply_force); end
        recover();
    endtask

    task automatic test_async_reset();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        tick();
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL ar_push: got %0b want 1", apply_force); end
        #2 Reset = 1'b1;
        #1;
        $display("async reset mid-push: af=%0b fx=%0d fy=%0d contact=%0b", apply_force, force_x, force_y, contact);
        checks++; if (apply_force !== 1'b0) begin failures++; $display("FAIL ar_af: got %0b want 0", apply_force); end
        checks++; if (force_x !== 10'sd0 || force_y !== 10'sd0) begin
            failures++; $display("FAIL ar_force: got %0d,%0d want 0,0", force_x, force_y);
        end
        checks++; if (contact !== 1'b0) begin failures++; $display("FAIL ar_contact: got %0b want 0", contact); end
        #1 Reset = 1'b0;
        recover();
    endtask

    task automatic test_kick();
`ifdef HEAD_BALL_KICK_EN
        int pulses;
        set_geom(300, 300, 260, 300, 15, 0, 0);
        facing = 1'b0;
        kick_btn = 1'b1;
        tick();
        $display("kick left: af=%0b fx=%0d fy=%0d contact=%0b", apply_force, force_x, force_y, contact);
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL kick_af: got %0b want 1", apply_force); end
        checks++; if (force_x !== -10'sd12) begin failures++; $display("FAIL kick_fx: got %0d want -12", force_x); end
        checks++; if (force_y !== -10'sd10) begin failures++; $display("FAIL kick_fy: got %0d want -10", force_y); end
        pulses = 0;
        for (int f = 0; f < 15; f++) begin
            tick();
            pulses += int'(apply_force);
        end
        $display("kick held: extra pulses=%0d", pulses);
        checks++; if (pulses != 0) begin failures++; $display("FAIL kick_hold: got %0d want 0", pulses); end
        kick_btn = 1'b0;
        repeat (2) tick();
        set_geom(300, 300, 320, 290, 15, 3, 0);
        facing = 1'b1;
        kick_btn = 1'b1;
        tick();
        $display("kick over bump: fx=%0d fy=%0d", force_x, force_y);
        checks++; if (force_x !== 10'sd12 || force_y !== -10'sd10) begin
            failures++; $display("FAIL kick_priority: got %0d,%0d want 12,-10", force_x, force_y);
        end
        recover();
        set_geom(300, 300, 254, 300, 15, 0, 0);
        kick_btn = 1'b1;
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            tick();
            pulses += int'(apply_force);
        end
        $display("kick out of reach: pulses=%0d", pulses);
        checks++; if (pulses != 0) begin failures++; $display("FAIL kick_out_of_reach: got %0d want 0", pulses); end
        recover();
        set_geom(300, 300, 255, 300, 15, 0, 0);
        facing = 1'b0;
        kick_btn = 1'b1;
        tick();
        $display("kick at reach edge: af=%0b fx=%0d", apply_force, force_x);
        checks++; if (apply_force !== 1'b1) begin failures++; $display("FAIL kick_reach_edge: got %0b want 1", apply_force); end
        recover();
`else
        int pulses;
        set_geom(300, 300, 260, 300, 15, 0, 0);
        facing = 1'b0;
        kick_btn = 1'b1;
        pulses = 0;
        for (int f = 0; f < 5; f++) begin
            tick();
            pulses += int'(apply_force);
        end
        $display("kick disabled: pulses=%0d", pulses);
        checks++; if (pulses != 0) begin failures++; $display("FAIL kick_disabled: got %0d want 0", pulses); end
        recover();
`endif
    endtask

    initial begin
        test_reset();
        test_bump();
        test_no_contact();
        test_saturation();
        test_cooldown();
        test_goal_reset();
        test_async_reset();
        test_kick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
